// File: rtl/exec_sequencer_pkg.sv
// Shared configuration for the picoMIPS execution sequencer: state encoding,
// debounce defaults and board switch field positions.
package exec_sequencer_pkg;

    localparam int unsigned DEBOUNCE_CYCLES_DEF = 4;
    localparam int unsigned DB_W_DEF            = 4;
    localparam int unsigned P_SIZE_DEF          = 6;

    // SW[8] is the operator handshake, SW[7:0] the immediate operand field
    localparam int unsigned SW_HANDSHAKE = 8;
    localparam int unsigned SW_IMM_W     = 8;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        WAIT_HI = 2'd1,
        WAIT_LO = 2'd2,
        HALT    = 2'd3
    } seq_state_t;

endpackage

// File: rtl/exec_sequencer_switch_debouncer.sv
// Two-flop synchroniser plus saturating-run debouncer for the handshake switch.
// sw_db only flips after DEBOUNCE_CYCLES consecutive differing synchronised samples.
module exec_sequencer_switch_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned DB_W            = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic sw_raw,
    output logic sw_db
);

    localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]      sync_q;
    logic            sw_sync;
    logic [DB_W-1:0] cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], sw_raw};
        end
    end

    assign sw_sync = sync_q[1];

    // Counter only runs while the synchronised level disagrees with sw_db
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            sw_db <= 1'b0;
        end else if (sw_sync != sw_db) begin
            if (cnt_q == CNT_LAST) begin
                cnt_q <= '0;
                sw_db <= ~sw_db;
            end else begin
                cnt_q <= cnt_q + DB_W'(1);
            end
        end else begin
            cnt_q <= '0;
        end
    end

endmodule

// File: rtl/exec_sequencer.sv
// Execution sequencer: gates PC advance, stalls on wait-for-switch instructions,
// strobes the immediate capture and latches HALT.
module exec_sequencer
    import exec_sequencer_pkg::*;
#(
    parameter int unsigned P_SIZE          = P_SIZE_DEF,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned DB_W            = DB_W_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sw_handshake,
    input  logic       wait_req,
    input  logic       halt_req,
    output logic       pc_en,
    output logic       imm_capture,
    output logic       halted,
    output logic [1:0] seq_state,
    output logic       sw_db
);

    seq_state_t state_q;
    seq_state_t state_d;

    // Parameter sanity: debounce terminal count must fit the counter
    always_comb begin : param_check
        assert (P_SIZE >= 1 && DEBOUNCE_CYCLES >= 1 && DEBOUNCE_CYCLES < (1 << DB_W))
            else $error("exec_sequencer: illegal parameter combination");
    end

    exec_sequencer_switch_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .DB_W            (DB_W)
    ) u_debouncer (
        .clk    (clk),
        .reset  (reset),
        .sw_raw (sw_handshake),
        .sw_db  (sw_db)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // HALT is absorbing; halt_req wins over wait_req in RUN
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN: begin
                if (halt_req) begin
                    state_d = HALT;
                end else if (wait_req) begin
                    state_d = WAIT_HI;
                end
            end
            WAIT_HI: begin
                if (sw_db) begin
                    state_d = WAIT_LO;
                end
            end
            WAIT_LO: begin
                if (!sw_db) begin
                    state_d = RUN;
                end
            end
            HALT:    state_d = HALT;
            default: state_d = RUN;
        endcase
    end

    // Strobes are held low for the whole reset assertion
    always_comb begin
        pc_en       = 1'b0;
        imm_capture = 1'b0;
        if (!reset) begin
            case (state_q)
                RUN:     pc_en       = !halt_req && !wait_req;
                WAIT_HI: imm_capture = sw_db;
                WAIT_LO: pc_en       = !sw_db;
                default: ;
            endcase
        end
    end

    assign halted    = (state_q == HALT);
    assign seq_state = state_q;

endmodule

// File: tb/tb_exec_sequencer.sv
// Directed bench for exec_sequencer: reset, handshake, bounce rejection,
// pre-pressed switch, halt priority and asynchronous reset mid-wait.
module tb_exec_sequencer;
    import exec_sequencer_pkg::*;

    logic                  clk;
    logic                  reset;
    logic [SW_HANDSHAKE:0] sw;
    logic                  wait_req;
    logic                  halt_req;
    logic                  pc_en;
    logic                  imm_capture;
    logic                  halted;
    logic [1:0]            seq_state;
    logic                  sw_db;

    int checks = 0;
    int errors = 0;

    exec_sequencer #(
        .P_SIZE          (6),
        .DEBOUNCE_CYCLES (4),
        .DB_W            (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .sw_handshake (sw[SW_HANDSHAKE]),
        .wait_req     (wait_req),
        .halt_req     (halt_req),
        .pc_en        (pc_en),
        .imm_capture  (imm_capture),
        .halted       (halted),
        .seq_state    (seq_state),
        .sw_db        (sw_db)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    // Request one wait cycle from RUN; returns just after the edge entering WAIT_HI
    task automatic enter_wait(input string tag);
        wait_req = 1'b1;
        @(negedge clk);
        chk({tag, "_req_pc_en"}, 32'(pc_en), 32'd0);
        chk({tag, "_req_state"}, 32'(seq_state), 32'd0);
        next();
        wait_req = 1'b0;
    endtask

    // Raise the switch in WAIT_HI: capture strobe lands 6 cycles after the raw rise
    task automatic press_check(input string tag);
        sw[SW_HANDSHAKE] = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            next();
            @(negedge clk);
            chk({tag, "_press_imm"},   32'(imm_capture), 32'(k == 6));
            chk({tag, "_press_swdb"},  32'(sw_db),       32'(k >= 6));
            chk({tag, "_press_state"}, 32'(seq_state),   (k <= 6) ? 32'd1 : 32'd2);
            chk({tag, "_press_pc_en"}, 32'(pc_en),       32'd0);
        end
        next();
        next();
    endtask

    // Drop the switch in WAIT_LO: pc_en pulses when sw_db falls, then RUN
    task automatic release_check(input string tag);
        sw[SW_HANDSHAKE] = 1'b0;
        for (int j = 1; j <= 8; j++) begin
            next();
            @(negedge clk);
            chk({tag, "_rel_swdb"},  32'(sw_db),       32'(j < 6));
            chk({tag, "_rel_pc_en"}, 32'(pc_en),       32'(j >= 6));
            chk({tag, "_rel_state"}, 32'(seq_state),   (j <= 6) ? 32'd2 : 32'd0);
            chk({tag, "_rel_imm"},   32'(imm_capture), 32'd0);
        end
        next();
    endtask

    initial begin
        reset    = 1'b1;
        sw       = '0;
        wait_req = 1'b0;
        halt_req = 1'b0;

        // 1: reset held three cycles, then free-running RUN
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_pc_en",  32'(pc_en),       32'd0);
            chk("rst_state",  32'(seq_state),   32'd0);
            chk("rst_imm",    32'(imm_capture), 32'd0);
            chk("rst_halted", 32'(halted),      32'd0);
            chk("rst_swdb",   32'(sw_db),       32'd0);
            next();
        end
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("run_pc_en", 32'(pc_en),       32'd1);
            chk("run_state", 32'(seq_state),   32'd0);
            chk("run_imm",   32'(imm_capture), 32'd0);
            next();
        end

        // 2: clean operator handshake
        enter_wait("hs");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hs_wait_state", 32'(seq_state),   32'd1);
            chk("hs_wait_pc_en", 32'(pc_en),       32'd0);
            chk("hs_wait_imm",   32'(imm_capture), 32'd0);
            next();
        end
        press_check("hs");
        release_check("hs");

        // 3: bouncing switch never reaches sw_db
        enter_wait("bnc");
        for (int i = 0; i < 20; i++) begin
            sw[SW_HANDSHAKE] = ((i / 2) % 2) == 0;
            @(negedge clk);
            chk("bnc_swdb",  32'(sw_db),       32'd0);
            chk("bnc_imm",   32'(imm_capture), 32'd0);
            chk("bnc_state", 32'(seq_state),   32'd1);
            next();
        end
        sw[SW_HANDSHAKE] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("bnc_tail_swdb",  32'(sw_db),     32'd0);
            chk("bnc_tail_state", 32'(seq_state), 32'd1);
            next();
        end
        press_check("bnc");
        release_check("bnc");

        // 4: switch already pressed before the wait instruction
        sw[SW_HANDSHAKE] = 1'b1;
        sw[SW_IMM_W-1:0] = 8'hA5;
        for (int k = 1; k <= 8; k++) begin
            next();
            @(negedge clk);
            chk("pre_swdb",  32'(sw_db),     32'(k >= 6));
            chk("pre_pc_en", 32'(pc_en),     32'd1);
            chk("pre_state", 32'(seq_state), 32'd0);
        end
        next();
        enter_wait("pre");
        @(negedge clk);
        chk("pre_hi_state", 32'(seq_state),   32'd1);
        chk("pre_hi_imm",   32'(imm_capture), 32'd1);
        chk("pre_hi_pc_en", 32'(pc_en),       32'd0);
        next();
        @(negedge clk);
        chk("pre_lo_state", 32'(seq_state),   32'd2);
        chk("pre_lo_imm",   32'(imm_capture), 32'd0);
        chk("pre_lo_pc_en", 32'(pc_en),       32'd0);
        next();
        release_check("pre");

        // 5: halt wins over wait and is absorbing
        wait_req = 1'b1;
        halt_req = 1'b1;
        @(negedge clk);
        chk("hlt_req_pc_en", 32'(pc_en), 32'd0);
        next();
        wait_req = 1'b0;
        halt_req = 1'b0;
        for (int i = 0; i < 20; i++) begin
            sw[SW_HANDSHAKE] = (i >= 2) && (i < 12);
            wait_req         = (i == 15);
            @(negedge clk);
            chk("hlt_state",  32'(seq_state),   32'd3);
            chk("hlt_halted", 32'(halted),      32'd1);
            chk("hlt_pc_en",  32'(pc_en),       32'd0);
            chk("hlt_imm",    32'(imm_capture), 32'd0);
            next();
        end
        wait_req = 1'b0;
        reset = 1'b1;
        #1;
        chk("hlt_rst_state",  32'(seq_state), 32'd0);
        chk("hlt_rst_halted", 32'(halted),    32'd0);
        chk("hlt_rst_pc_en",  32'(pc_en),     32'd0);
        next();
        reset = 1'b0;
        @(negedge clk);
        chk("hlt_after_pc_en", 32'(pc_en),     32'd1);
        chk("hlt_after_state", 32'(seq_state), 32'd0);
        next();

        // 6: asynchronous reset between edges while in WAIT_LO
        enter_wait("ar");
        sw[SW_HANDSHAKE] = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            next();
        end
        @(negedge clk);
        chk("ar_pre_state", 32'(seq_state), 32'd2);
        chk("ar_pre_pc_en", 32'(pc_en),     32'd0);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("ar_state",  32'(seq_state),   32'd0);
        chk("ar_pc_en",  32'(pc_en),       32'd0);
        chk("ar_imm",    32'(imm_capture), 32'd0);
        chk("ar_swdb",   32'(sw_db),       32'd0);
        chk("ar_halted", 32'(halted),      32'd0);
        sw[SW_HANDSHAKE] = 1'b0;
        next();
        next();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("ar_after_pc_en", 32'(pc_en),       32'd1);
            chk("ar_after_imm",   32'(imm_capture), 32'd0);
            chk("ar_after_state", 32'(seq_state),   32'd0);
            chk("ar_after_swdb",  32'(sw_db),       32'd0);
            next();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
